// File: rtl/maxpool2x2_packed4b_if.sv
// Memory-side bus of the 2x2 max-pool stage: one synchronous source read
// port and one destination write port, both word addressed.
interface maxpool2x2_packed4b_if #(
  parameter int AW = 12
);
  logic [AW-1:0] src_addr;
  logic          src_en;
  logic [31:0]   src_rdata;
  logic [AW-1:0] dst_addr;
  logic [31:0]   dst_wdata;
  logic          dst_en;
  logic [3:0]    dst_we;

  // Pooling engine side
  modport master (
    output src_addr, src_en, dst_addr, dst_wdata, dst_en, dst_we,
    input  src_rdata
  );

  // RAM side
  modport slave (
    input  src_addr, src_en, dst_addr, dst_wdata, dst_en, dst_we,
    output src_rdata
  );
endinterface

// File: rtl/maxpool2x2_packed4b.sv
// 2x2 / stride-2 max-pool over 4-bit packed activation planes.
// Each output word is built from four source reads (T0, B0, T1, B1) and
// written in one cycle: 4 FETCH + 1 DRAIN + 1 WRITE = 6 cycles per word.
// Optional build macro: MAXPOOL_RELU_EN clamps negative pooled nibbles to 0.
module maxpool2x2_packed4b #(
  parameter int IM_W   = 32,
  parameter int IM_H   = 32,
  parameter int NUM_CH = 32,
  parameter int AW     = 12
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic busy,
  output logic done,
  maxpool2x2_packed4b_if.master bus
);

  localparam int ROW_WORDS = IM_W / 8;
  localparam int OW_N      = IM_W / 16;
  localparam int R_N       = IM_H / 2;
  localparam int OWW       = (OW_N   > 1) ? $clog2(OW_N)   : 1;
  localparam int RW        = (R_N    > 1) ? $clog2(R_N)    : 1;
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t         state;
  logic [1:0]     k;
  logic [OWW-1:0] ow;
  logic [RW-1:0]  r;
  logic [CHW-1:0] ch;
  logic [AW-1:0]  tbase;      // address of T0 for the current output word
  logic [31:0]    t0_w, b0_w, t1_w;

  logic last_ow, last_r, last_ch;
  assign last_ow = (ow == OWW'(OW_N - 1));
  assign last_r  = (r  == RW'(R_N - 1));
  assign last_ch = (ch == CHW'(NUM_CH - 1));

  // Read k of a word: bit0 selects the bottom row, bit1 the right-hand word.
  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] base,
                                            input logic [1:0]    kk);
    rd_addr = base + (kk[0] ? AW'(ROW_WORDS) : '0) + {{(AW-1){1'b0}}, kk[1]};
  endfunction

  // Pool two vertically adjacent word pairs into one packed output word.
  function automatic logic [31:0] pool(input logic [31:0] t0, input logic [31:0] b0,
                                       input logic [31:0] t1, input logic [31:0] b1);
    logic [31:0]       t, b;
    logic signed [3:0] mx, c1, c2, c3;
    pool = '0;
    for (int n = 0; n < 8; n++) begin
      int m;
      m  = n % 4;
      t  = (n < 4) ? t0 : t1;
      b  = (n < 4) ? b0 : b1;
      mx = t[31-8*m -: 4];
      c1 = t[27-8*m -: 4];
      c2 = b[31-8*m -: 4];
      c3 = b[27-8*m -: 4];
      if (c1 > mx) mx = c1;
      if (c2 > mx) mx = c2;
      if (c3 > mx) mx = c3;
`ifdef MAXPOOL_RELU_EN
      if (mx < 0) mx = '0;
`else
`endif
      pool[31-4*n -: 4] = mx;
    end
  endfunction

  // Sequencer: counters, read addressing, slot capture and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      k             <= '0;
      ow            <= '0;
      r             <= '0;
      ch            <= '0;
      tbase         <= '0;
      t0_w          <= '0;
      b0_w          <= '0;
      t1_w          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.src_addr  <= '0;
      bus.src_en    <= 1'b0;
      bus.dst_addr  <= '0;
      bus.dst_wdata <= '0;
      bus.dst_en    <= 1'b0;
      bus.dst_we    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            k            <= '0;
            ow           <= '0;
            r            <= '0;
            ch           <= '0;
            tbase        <= '0;
            bus.dst_addr <= '0;
            bus.src_addr <= '0;
            bus.src_en   <= 1'b1;
            busy         <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Data for read k-1 is on src_rdata this cycle.
          case (k)
            2'd1:    t0_w <= bus.src_rdata;
            2'd2:    b0_w <= bus.src_rdata;
            2'd3:    t1_w <= bus.src_rdata;
            default: ;
          endcase
          if (k == 2'd3) begin
            bus.src_en <= 1'b0;
            state      <= S_DRAIN;
          end else begin
            k            <= k + 2'd1;
            bus.src_addr <= rd_addr(tbase, k + 2'd1);
          end
        end
        S_DRAIN: begin
          // B1 arrives now; fold it straight into the output word.
          bus.dst_wdata <= pool(t0_w, b0_w, t1_w, bus.src_rdata);
          bus.dst_en    <= 1'b1;
          bus.dst_we    <= 4'b1111;
          state         <= S_WRITE;
        end
        S_WRITE: begin
          bus.dst_en   <= 1'b0;
          bus.dst_we   <= '0;
          bus.dst_addr <= bus.dst_addr + AW'(1);
          // Past the last pair of a row the bottom row is skipped as well.
          tbase <= tbase + AW'(2) + (last_ow ? AW'(ROW_WORDS) : '0);
          ow    <= last_ow ? '0 : ow + OWW'(1);
          if (last_ow) begin
            r <= last_r ? '0 : r + RW'(1);
            if (last_r) ch <= last_ch ? '0 : ch + CHW'(1);
          end
          if (last_ow && last_r && last_ch) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            k            <= '0;
            bus.src_addr <= tbase + AW'(2) + (last_ow ? AW'(ROW_WORDS) : '0);
            bus.src_en   <= 1'b1;
            state        <= S_FETCH;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2x2_packed4b.sv
// Scoreboard bench for maxpool2x2_packed4b at default geometry.
module tb_maxpool2x2_packed4b;
  localparam int IM_W   = 32;
  localparam int IM_H   = 32;
  localparam int NUM_CH = 32;
  localparam int AW     = 12;
  localparam int NW     = NUM_CH * IM_W * IM_H / 8;
  localparam int NOUT   = NW / 4;
  localparam int NWORDS = NUM_CH * (IM_H / 2) * (IM_W / 16);

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  maxpool2x2_packed4b_if #(.AW(AW)) mif ();

  maxpool2x2_packed4b #(.IM_W(IM_W), .IM_H(IM_H), .NUM_CH(NUM_CH), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .bus(mif)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NW];
  exp_t        q[$];
  exp_t        e;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, st_cyc = 0, done_cyc = 0, last_wr_cyc = 0;
  int wr_cnt = 0, done_cnt = 0;
  logic [31:0] first_wd;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read source RAM
  always @(posedge clk) if (mif.src_en) mif.src_rdata <= mem[mif.src_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic signed [3:0] pix(input int c, input int y, input int x);
    logic [31:0] w;
    w = mem[c*(IM_W*IM_H/8) + y*(IM_W/8) + x/8];
    return w[31-4*(x%8) -: 4];
  endfunction

  // Reference: pool by pixel coordinates, then pack by output x.
  function automatic logic [31:0] ref_word(input int c, input int oy, input int owd);
    logic [31:0] w;
    logic signed [3:0] mx, v;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      int ox;
      ox = owd*8 + j;
      mx = -4'sd8;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          v = pix(c, 2*oy+dy, 2*ox+dx);
          if (v > mx) mx = v;
        end
`ifdef MAXPOOL_RELU_EN
      if (mx < 0) mx = '0;
`endif
      w[31-4*j -: 4] = mx;
    end
    return w;
  endfunction

  // Output monitor: every write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetn && mif.dst_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (wr_cnt == 1) first_wd = mif.dst_wdata;
      if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("dst_addr", 32'(mif.dst_addr), 32'(e.a));
        chk("dst_wdata", mif.dst_wdata, e.d);
        chk("dst_we", 32'(mif.dst_we), 32'hF);
      end
    end
    if (resetn && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    st_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < NW; i++)
      case (mode)
        0:       mem[i] = $urandom;
        1:       mem[i] = 32'h88888888;
        default: mem[i] = 32'h33333333;
      endcase
    if (mode == 0) begin
      mem[0] = 32'h01234567;                // T0
      mem[IM_W/8] = 32'h89ABCDEF;           // B0
      mem[1] = 32'h7F7F7F7F;                // T1
      mem[IM_W/8 + 1] = 32'h00000000;       // B1
    end
  endtask

  task automatic run_case(input int mode, input bit dbl_start);
    int budget;
    exp_t x;
    fill(mode);
    q.delete();
    for (int c = 0; c < NUM_CH; c++)
      for (int oy = 0; oy < IM_H/2; oy++)
        for (int owd = 0; owd < IM_W/16; owd++) begin
          x.a = AW'(c*(IM_W*IM_H/32) + oy*(IM_W/16) + owd);
          x.d = ref_word(c, oy, owd);
          q.push_back(x);
        end
    wr_cnt = 0;
    done_cnt = 0;
    pulse_start();
    chk("first_src_en", 32'(mif.src_en), 32'd1);
    chk("first_src_addr", 32'(mif.src_addr), 32'd0);
    chk("busy_run", 32'(busy), 32'd1);
    if (dbl_start) begin
      repeat (98) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    budget = 20000;
    while (done_cnt == 0 && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    if (done_cnt != 0) begin
      // Start cycle and done cycle inclusive span 6*words + 2 cycles.
      chk("done_latency", 32'(done_cyc - st_cyc), 32'(6*NWORDS + 1));
      chk("done_after_last_wr", 32'(done_cyc - last_wr_cyc), 32'd1);
      chk("write_count", 32'(wr_cnt), 32'(NOUT));
      chk("queue_empty", 32'(q.size()), 32'd0);
      case (mode)
        0: chk("dst0_pattern", first_wd, 32'h13577777);
`ifdef MAXPOOL_RELU_EN
        1: chk("dst0_neg", first_wd, 32'h00000000);
`else
        1: chk("dst0_neg", first_wd, 32'h88888888);
`endif
        default: chk("dst0_threes", first_wd, 32'h33333333);
      endcase
      @(negedge clk);
      chk("busy_after", 32'(busy), 32'd0);
      chk("done_pulse_len", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #2 resetn = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_src_en", 32'(mif.src_en), 32'd0);
    chk("rst_dst_en", 32'(mif.dst_en), 32'd0);
    chk("rst_dst_we", 32'(mif.dst_we), 32'd0);
    chk("rst_src_addr", 32'(mif.src_addr), 32'd0);
    chk("rst_dst_addr", 32'(mif.dst_addr), 32'd0);
    chk("rst_dst_wdata", mif.dst_wdata, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    run_case(0, 1'b1);
    run_case(1, 1'b0);
    run_case(2, 1'b0);

    // Reset in the middle of FETCH, then restart from scratch.
    fill(0);
    q.delete();
    wr_cnt = 0;
    pulse_start();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_src_en", 32'(mif.src_en), 32'd0);
    chk("midrst_dst_en", 32'(mif.dst_en), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_write", 32'(wr_cnt), 32'd0);
    pulse_start();
    chk("restart_src_en", 32'(mif.src_en), 32'd1);
    chk("restart_addr0", 32'(mif.src_addr), 32'd0);
    @(negedge clk);
    chk("restart_addr1", 32'(mif.src_addr), 32'(IM_W/8));
    resetn = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
